// File: rtl/rdmx_rx_pkg.sv
// Shared types and helpers for the RDMX receive-side AXI4 write responder.
package rdmx_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bytes carried by one full-width data beat.
    function automatic int unsigned bytes_per_beat(input int unsigned dw);
        return dw / 32'd8;
    endfunction

endpackage

// File: rtl/rdmx_axi_to_stream_if.sv
// AXI4 write-slave channels plus the AXI4-Stream output of the RDMX rx responder.
interface rdmx_axi_to_stream_if #(
    parameter int DW = 512,
    parameter int AW = 64,
    parameter int IW = 4,
    parameter int UW = 32
) ();
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [UW-1:0]   S_AXI_AWUSER;
    logic [IW-1:0]   S_AXI_AWID;
    logic [7:0]      S_AXI_AWLEN;
    logic [2:0]      S_AXI_AWSIZE;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WLAST;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [IW-1:0]   S_AXI_BID;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [DW-1:0]   AXIS_OUT_TDATA;
    logic            AXIS_OUT_TLAST;
    logic            AXIS_OUT_TVALID;
    logic            AXIS_OUT_TREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWUSER, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE,
        input  S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_BREADY, AXIS_OUT_TREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWUSER, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE,
        output S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_BREADY, AXIS_OUT_TREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID
    );
endinterface

// File: rtl/rdmx_rx_counters.sv
// Byte/burst/block accounting for the RDMX rx path. Blocks end on byte count
// alone, independent of where burst boundaries fall.
module rdmx_rx_counters
    import rdmx_rx_pkg::*;
#(
    parameter int DW          = 512,
    parameter int BLOCK_BYTES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        beat_i,
    input  logic        burst_done_i,
    output logic [31:0] burst_count_o,
    output logic [31:0] block_count_o,
    output logic        block_done_o
);
    localparam int BCW = $clog2(BLOCK_BYTES) + 1;
    localparam logic [BCW-1:0] BPB_C   = BCW'(bytes_per_beat(DW));
    localparam logic [BCW-1:0] BLOCK_C = BCW'(BLOCK_BYTES);

    logic [BCW-1:0] byte_ctr_q;
    logic [BCW-1:0] byte_ctr_d;
    logic [BCW-1:0] byte_sum_s;
    logic           block_end_s;
    logic [31:0]    burst_count_q;
    logic [31:0]    block_count_q;
    logic           block_done_q;

    // Advance the byte count per beat and detect the beat that closes a block.
    always_comb begin
        byte_sum_s  = byte_ctr_q + BPB_C;
        byte_ctr_d  = byte_ctr_q;
        block_end_s = 1'b0;
        if (beat_i) begin
            if (byte_sum_s == BLOCK_C) begin
                byte_ctr_d  = {BCW{1'b0}};
                block_end_s = 1'b1;
            end else begin
                byte_ctr_d  = byte_sum_s;
            end
        end else begin
            byte_ctr_d = byte_ctr_q;
        end
    end

    // Counter state; block_done is the registered block-end strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_ctr_q    <= {BCW{1'b0}};
            burst_count_q <= 32'd0;
            block_count_q <= 32'd0;
            block_done_q  <= 1'b0;
        end else begin
            byte_ctr_q   <= byte_ctr_d;
            block_done_q <= block_end_s;
            if (block_end_s) begin
                block_count_q <= block_count_q + 32'd1;
            end
            if (burst_done_i) begin
                burst_count_q <= burst_count_q + 32'd1;
            end
        end
    end

    assign burst_count_o = burst_count_q;
    assign block_count_o = block_count_q;
    assign block_done_o  = block_done_q;
endmodule

// File: rtl/rdmx_axi_to_stream.sv
// RDMX receive-side AXI4 write responder: forwards write beats as AXI4-Stream
// beats, one burst in flight, one B response per burst.
// Optional burst checking (WLAST/WSTRB/AWSIZE) is built with RDMX_RX_CHECK_EN.
module rdmx_axi_to_stream
    import rdmx_rx_pkg::*;
#(
    parameter int DW          = 512,
    parameter int AW          = 64,
    parameter int IW          = 4,
    parameter int UW          = 32,
    parameter int BLOCK_BYTES = 1048576
) (
    input  logic                 clk,
    input  logic                 reset,
    rdmx_axi_to_stream_if.slave  axi,
    output logic [UW-1:0]        last_awuser,
    output logic [31:0]          burst_count,
    output logic [31:0]          block_count,
    output logic                 block_done,
    output logic                 proto_error
);
    state_e        state_q, state_d;
    logic [7:0]    beat_ctr_q, beat_ctr_d;
    logic [7:0]    len_q;
    logic [IW-1:0] id_q;
    logic [UW-1:0] user_q;
    logic          awready_q;
    logic          aw_hs_s, w_hs_s, b_hs_s, tlast_s;
    logic [1:0]    bresp_s;

    assign aw_hs_s = (state_q == S_IDLE) && awready_q && axi.S_AXI_AWVALID;
    assign w_hs_s  = (state_q == S_DATA) && axi.S_AXI_WVALID && axi.AXIS_OUT_TREADY;
    assign b_hs_s  = (state_q == S_RESP) && axi.S_AXI_BREADY;
    // Last beat is defined by the latched AWLEN, never by the master's WLAST.
    assign tlast_s = (state_q == S_DATA) && (beat_ctr_q == len_q);

    // Next-state logic for the one-burst-at-a-time handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (aw_hs_s) state_d = S_DATA;
                else         state_d = S_IDLE;
            end
            S_DATA: begin
                if (w_hs_s && tlast_s) state_d = S_RESP;
                else                   state_d = S_DATA;
            end
            S_RESP: begin
                if (b_hs_s) state_d = S_IDLE;
                else        state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat position within the current burst.
    always_comb begin
        beat_ctr_d = beat_ctr_q;
        if (aw_hs_s)     beat_ctr_d = 8'd0;
        else if (w_hs_s) beat_ctr_d = beat_ctr_q + 8'd1;
        else             beat_ctr_d = beat_ctr_q;
    end

    // State, burst attributes and the registered AWREADY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_ctr_q <= 8'd0;
            len_q      <= 8'd0;
            id_q       <= {IW{1'b0}};
            user_q     <= {UW{1'b0}};
            awready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_ctr_q <= beat_ctr_d;
            awready_q  <= (state_d == S_IDLE);
            if (aw_hs_s) begin
                len_q  <= axi.S_AXI_AWLEN;
                id_q   <= axi.S_AXI_AWID;
                user_q <= axi.S_AXI_AWUSER;
            end
        end
    end

`ifdef RDMX_RX_CHECK_EN
    localparam logic [2:0] SIZE_C = 3'($clog2(DW/8));
    logic [2:0] size_q;
    logic       err_q;
    logic       perr_q;
    logic       beat_err_s;

    assign beat_err_s = w_hs_s && ((axi.S_AXI_WLAST != tlast_s) ||
                                   (axi.S_AXI_WSTRB != {(DW/8){1'b1}}) ||
                                   (size_q != SIZE_C));

    // Per-burst error flag (cleared on AW) and sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q <= 3'd0;
            err_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                size_q <= axi.S_AXI_AWSIZE;
                err_q  <= 1'b0;
            end else if (beat_err_s) begin
                err_q  <= 1'b1;
            end
            perr_q <= perr_q | beat_err_s;
        end
    end

    assign bresp_s     = ((state_q == S_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign proto_error = perr_q;
`else
    assign bresp_s     = RESP_OKAY;
    assign proto_error = 1'b0;
`endif

    assign axi.S_AXI_AWREADY   = awready_q;
    assign axi.S_AXI_WREADY    = (state_q == S_DATA) && axi.AXIS_OUT_TREADY;
    assign axi.AXIS_OUT_TVALID = (state_q == S_DATA) && axi.S_AXI_WVALID;
    assign axi.AXIS_OUT_TDATA  = axi.S_AXI_WDATA;
    assign axi.AXIS_OUT_TLAST  = tlast_s;
    assign axi.S_AXI_BVALID    = (state_q == S_RESP);
    assign axi.S_AXI_BID       = id_q;
    assign axi.S_AXI_BRESP     = bresp_s;
    assign last_awuser         = user_q;

    rdmx_rx_counters #(
        .DW          (DW),
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_counters (
        .clk           (clk),
        .reset         (reset),
        .beat_i        (w_hs_s),
        .burst_done_i  (b_hs_s),
        .burst_count_o (burst_count),
        .block_count_o (block_count),
        .block_done_o  (block_done)
    );
endmodule

// File: tb/tb_rdmx_axi_to_stream.sv
// Directed self-checking bench for rdmx_axi_to_stream (DW=512, 1 MiB blocks).
module tb_rdmx_axi_to_stream;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int UW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [UW-1:0] last_awuser;
    logic [31:0] burst_count;
    logic [31:0] block_count;
    logic        block_done;
    logic        proto_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int blk_pulses = 0;
    int blk_pulse_cyc = -1;
    int last_beat_cyc = 0;

    rdmx_axi_to_stream_if #(.DW(DW), .AW(AW), .IW(IW), .UW(UW)) axi ();

    rdmx_axi_to_stream #(
        .DW(DW), .AW(AW), .IW(IW), .UW(UW), .BLOCK_BYTES(1048576)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .axi         (axi.slave),
        .last_awuser (last_awuser),
        .burst_count (burst_count),
        .block_count (block_count),
        .block_done  (block_done),
        .proto_error (proto_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (block_done === 1'b1) begin
            blk_pulses    = blk_pulses + 1;
            blk_pulse_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] data_pat(input int burst, input int beat);
        logic [31:0] w;
        w = {burst[15:0], beat[15:0]};
        return {16{w}};
    endfunction

    task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [31:0] user);
        bit ok;
        ok = 1'b0;
        axi.S_AXI_AWID    = id;
        axi.S_AXI_AWLEN   = len;
        axi.S_AXI_AWUSER  = user;
        axi.S_AXI_AWADDR  = 64'h0;
        axi.S_AXI_AWSIZE  = 3'd6;
        axi.S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (axi.S_AXI_AWREADY === 1'b1);
            tick();
        end
        axi.S_AXI_AWVALID = 1'b0;
        check_val("aw_accept", ok, 1);
    endtask

    task automatic send_burst(input int burst, input logic [7:0] len, input int n_beats,
                              input int wlast_idx, input bit toggle, output int cycles);
        int b;
        b = 0;
        cycles = 0;
        while (b < n_beats && cycles < 400) begin
            axi.AXIS_OUT_TREADY = toggle ? ((cycles % 2) == 0) : 1'b1;
            axi.S_AXI_WVALID    = 1'b1;
            axi.S_AXI_WDATA     = data_pat(burst, b);
            axi.S_AXI_WSTRB     = {(DW/8){1'b1}};
            axi.S_AXI_WLAST     = (b == wlast_idx);
            @(negedge clk);
            if (toggle) check_val("wready_mirror", axi.S_AXI_WREADY, axi.AXIS_OUT_TREADY);
            if (axi.S_AXI_WREADY === 1'b1) begin
                check_val("tvalid", axi.AXIS_OUT_TVALID, 1);
                check_val("tdata", axi.AXIS_OUT_TDATA, data_pat(burst, b));
                check_val("tlast", axi.AXIS_OUT_TLAST, (b == int'(len)));
                last_beat_cyc = cyc;
                b++;
            end
            tick();
            cycles++;
        end
        axi.S_AXI_WVALID    = 1'b0;
        axi.S_AXI_WLAST     = 1'b0;
        axi.AXIS_OUT_TREADY = 1'b1;
        check_val("beats_done", b, n_beats);
    endtask

    task automatic wait_b(input logic [3:0] exp_id, input logic [1:0] exp_resp, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        axi.S_AXI_BREADY = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (axi.S_AXI_BVALID === 1'b1) begin
                got = 1'b1;
                check_val("bid", axi.S_AXI_BID, exp_id);
                check_val("bresp", axi.S_AXI_BRESP, exp_resp);
            end else begin
                lat++;
            end
            tick();
        end
        axi.S_AXI_BREADY = 1'b0;
        check_val("b_seen", got, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_awready"}, axi.S_AXI_AWREADY, 0);
        check_val({tag, "_wready"}, axi.S_AXI_WREADY, 0);
        check_val({tag, "_bvalid"}, axi.S_AXI_BVALID, 0);
        check_val({tag, "_tvalid"}, axi.AXIS_OUT_TVALID, 0);
        check_val({tag, "_tlast"}, axi.AXIS_OUT_TLAST, 0);
        check_val({tag, "_bid"}, axi.S_AXI_BID, 0);
        check_val({tag, "_bresp"}, axi.S_AXI_BRESP, 0);
        check_val({tag, "_awuser"}, last_awuser, 0);
        check_val({tag, "_burst_count"}, burst_count, 0);
        check_val({tag, "_block_count"}, block_count, 0);
        check_val({tag, "_block_done"}, block_done, 0);
        check_val({tag, "_proto_error"}, proto_error, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        int lat;
        int pulses0;

        reset = 1'b1;
        axi.S_AXI_AWADDR    = 64'h0;
        axi.S_AXI_AWUSER    = 32'h0;
        axi.S_AXI_AWID      = 4'h0;
        axi.S_AXI_AWLEN     = 8'h0;
        axi.S_AXI_AWSIZE    = 3'd6;
        axi.S_AXI_AWVALID   = 1'b0;
        axi.S_AXI_WDATA     = {DW{1'b0}};
        axi.S_AXI_WSTRB     = {(DW/8){1'b1}};
        axi.S_AXI_WLAST     = 1'b0;
        axi.S_AXI_WVALID    = 1'b1;
        axi.S_AXI_BREADY    = 1'b0;
        axi.AXIS_OUT_TREADY = 1'b1;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        axi.S_AXI_WVALID = 1'b0;
        reset = 1'b0;
        tick();
        @(negedge clk);
        check_val("awready_after_reset", axi.S_AXI_AWREADY, 1);
        tick();

        // Single 64-beat burst, ID 5
        send_aw(4'd5, 8'd63, 32'h1234_5678);
        send_burst(1, 8'd63, 64, 63, 1'b0, ncyc);
        check_val("burst_cycles", ncyc, 64);
        wait_b(4'd5, 2'b00, lat);
        check_val("b_latency", lat, 0);
        @(negedge clk);
        check_val("awready_after_b", axi.S_AXI_AWREADY, 1);
        check_val("burst_count_1", burst_count, 1);
        tick();

        // AWLEN=0 with distinctive AWUSER
        send_aw(4'd2, 8'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("last_awuser", last_awuser, 32'hDEAD_BEEF);
        tick();
        send_burst(2, 8'd0, 1, 0, 1'b0, ncyc);
        wait_b(4'd2, 2'b00, lat);

        // TREADY toggling every cycle
        send_aw(4'd3, 8'd63, 32'h0000_0003);
        send_burst(3, 8'd63, 64, 63, 1'b1, ncyc);
        wait_b(4'd3, 2'b00, lat);
        @(negedge clk);
        check_val("burst_count_3", burst_count, 3);
        tick();

        // Early WLAST on beat 2 of a 4-beat burst
        send_aw(4'd7, 8'd3, 32'h0000_0007);
        send_burst(4, 8'd3, 4, 2, 1'b0, ncyc);
`ifdef RDMX_RX_CHECK_EN
        wait_b(4'd7, 2'b10, lat);
        @(negedge clk);
        check_val("proto_error_set", proto_error, 1);
`else
        wait_b(4'd7, 2'b00, lat);
        @(negedge clk);
        check_val("proto_error_off", proto_error, 0);
`endif
        tick();

        // Reset after 10 beats of a 64-beat burst
        send_aw(4'd9, 8'd63, 32'hCAFE_0001);
        send_burst(5, 8'd63, 10, 99, 1'b0, ncyc);
        axi.S_AXI_WVALID    = 1'b1;
        axi.AXIS_OUT_TREADY = 1'b1;
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        axi.S_AXI_WVALID = 1'b0;
        reset = 1'b0;
        send_aw(4'd1, 8'd0, 32'h0000_0001);
        send_burst(6, 8'd0, 1, 0, 1'b0, ncyc);
        wait_b(4'd1, 2'b00, lat);
        @(negedge clk);
        check_val("burst_count_after_rst", burst_count, 1);
        tick();

        // 256 back-to-back 4096-byte bursts make exactly one 1 MiB block
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        pulses0 = blk_pulses;
        for (int k = 0; k < 256; k++) begin
            send_aw(4'(k), 8'd63, k);
            send_burst(100 + k, 8'd63, 64, 63, 1'b0, ncyc);
            wait_b(4'(k), 2'b00, lat);
        end
        @(negedge clk);
        check_val("block_pulses", blk_pulses - pulses0, 1);
        check_val("block_pulse_cycle", blk_pulse_cyc, last_beat_cyc + 1);
        check_val("block_count", block_count, 1);
        check_val("burst_count_256", burst_count, 256);
        check_val("block_done_idle", block_done, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
